sort_mem_arbiter: RTL and testbench
===================================

SORT_MEM_ARBITER -- requirements
Module: sort_mem_arbiter

Interface
REQ-001 Parameter AW, default 3, meaning memory address width (2^AW words).
REQ-002 Parameter DW, default 8, meaning memory data width.
REQ-003 Parameter TIMEOUT, default 64, meaning wait-cycle limit before the starvation flag sets (1..255).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req0, we0, lock0  input  1 each  host port: request, write enable, lock request.
REQ-007 addr0 / wdata0  input  AW / DW  host port address and write data.
REQ-008 req1, we1, lock1  input  1 each  sorter-datapath port: request, write enable, lock request.
REQ-009 addr1 / wdata1  input  AW / DW  sorter port address and write data.
REQ-010 gnt0, gnt1  output  1 each  grant; an access is accepted in any cycle where reqN && gntN.
REQ-011 rvalid0, rvalid1  output  1 each  read data valid for port N.
REQ-012 rdata  output  DW  read data, a direct pass-through of mem_rdata.
REQ-013 mem_en, mem_we  output  1 each  single-port RAM enable and write enable.
REQ-014 mem_addr / mem_wdata  output  AW / DW  RAM address and write data.
REQ-015 mem_rdata  input  DW  RAM read data, valid one cycle after an enabled read.
REQ-016 starve_err  output  1  sticky starvation flag.

Function
REQ-017 gnt0/gnt1 SHALL be combinational from state, ptr, req0 and req1; at most one is high; gntN implies reqN.
REQ-018 The FSM SHALL have states IDLE (no owner), OWN0 and OWN1 (port locked).
REQ-019 IDLE, single request: the requester SHALL be granted in the same cycle.
REQ-020 IDLE, both requesting: the port selected by the 1-bit round-robin pointer ptr SHALL be granted (ptr=0 favours port 0); after any accepted access by port N, ptr SHALL become the other port.
REQ-021 IDLE, accepted access with lockN=1: next state SHALL be OWN_N.
REQ-022 OWN_N: gnt SHALL go only to port N (when reqN); the other port SHALL be refused.
REQ-023 OWN_N: the FSM SHALL return to IDLE on the first cycle lockN=0, and that cycle SHALL arbitrate as IDLE.
REQ-024 mem_en SHALL equal (gnt0&&req0)||(gnt1&&req1); mem_we, mem_addr and mem_wdata SHALL be the granted port's we/addr/wdata; with no grant, mem_we=0 and addr/wdata=0.
REQ-025 An accepted read (weN=0) SHALL assert rvalidN, registered, for exactly one cycle, in the following cycle; writes SHALL produce no rvalid.
REQ-026 Back-to-back accepted reads SHALL produce back-to-back rvalid pulses; at most one rvalid is high per cycle.
REQ-027 An 8-bit wait counter per port SHALL increment (saturating at 255) each cycle reqN=1 && gntN=0, and SHALL clear on the cycle port N is granted or reqN=0.
REQ-028 starve_err SHALL set on the cycle either wait counter reaches TIMEOUT, and SHALL stay set until reset.
REQ-029 Dropping reqN without a grant SHALL be legal and SHALL have no side effects beyond clearing waitN.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, ptr=0, rvalid0=rvalid1=0, both wait counters=0, starve_err=0.
REQ-031 A reset during an outstanding read SHALL discard its rvalid; a held lock SHALL be released.
REQ-032 While rst=1, gnt0, gnt1, mem_en and mem_we SHALL be 0.

Verification
REQ-033 Only req0 issues a read at addr 5; the RAM model holds 0x3C -> gnt0=1 in the same cycle, mem_addr=5, rvalid0=1 and rdata=0x3C in the next cycle.
REQ-034 req0 and req1 both held for 4 cycles with no lock, starting from reset -> grants alternate 0,1,0,1.
REQ-035 Port 1 is granted with lock1=1 and holds the lock for 10 cycles while req0 is held -> gnt0=0 throughout; on the first cycle with lock1=0, gnt0=1.
REQ-036 TIMEOUT=4, port 1 locked and req0 held -> starve_err=1 on the 4th wait cycle and remains 1 after the lock releases.
REQ-037 Port 1 write of 0xA5 to addr 2 is followed by a port 0 read of addr 2 -> rdata=0xA5 with rvalid0=1, rvalid1=0.
REQ-038 rst asserted in the cycle after an accepted read -> no rvalid appears, state=IDLE, and ptr=0.

Source files
------------

// File: rtl/sort_mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM: host (port 0) and sorter datapath (port 1).
// Round-robin in IDLE, lock-based ownership, one-cycle read-valid pulses and a sticky starvation flag.
module sort_mem_arbiter #(
    parameter int AW      = 3,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          starve_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam logic [7:0] WAIT_LIMIT = TIMEOUT[7:0];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0] state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic [7:0] wait0_q, wait0_d;
    logic [7:0] wait1_q, wait1_d;
    logic       starve_q, starve_d;

    logic own0_held;
    logic own1_held;
    logic acc0;
    logic acc1;

    // Ownership persists only while the owner keeps its lock high; the release cycle arbitrates as IDLE.
    assign own0_held = (state_q == OWN0) && lock0;
    assign own1_held = (state_q == OWN1) && lock1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (own0_held) begin
            gnt0 = req0;
        end else if (own1_held) begin
            gnt1 = req1;
        end else if (req0 && req1) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign acc0 = gnt0 && req0;
    assign acc1 = gnt1 && req1;

    always_comb begin
        mem_en    = acc0 || acc1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (acc1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!own0_held && !own1_held) begin
            state_d = IDLE;
            if (acc0 && lock0) begin
                state_d = OWN0;
            end else if (acc1 && lock1) begin
                state_d = OWN1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (acc0) begin
            ptr_d = 1'b1;
        end else if (acc1) begin
            ptr_d = 1'b0;
        end
    end

    always_comb begin
        rvalid0_d = acc0 && !we0;
        rvalid1_d = acc1 && !we1;
        wait0_d   = (req0 && !gnt0) ? sat_inc(wait0_q) : 8'd0;
        wait1_d   = (req1 && !gnt1) ? sat_inc(wait1_q) : 8'd0;
        starve_d  = starve_q || (wait0_d >= WAIT_LIMIT) || (wait1_d >= WAIT_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            wait0_q   <= 8'd0;
            wait1_q   <= 8'd0;
            starve_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            wait0_q   <= wait0_d;
            wait1_q   <= wait1_d;
            starve_q  <= starve_d;
        end
    end

    // A reset arriving while a read is in flight suppresses that read's valid pulse.
    assign rvalid0    = rvalid0_q && !rst;
    assign rvalid1    = rvalid1_q && !rst;
    assign rdata      = mem_rdata;
    assign starve_err = starve_q;

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Directed bench for sort_mem_arbiter with a 1-cycle RAM model and a read-data scoreboard queue.
module tb_sort_mem_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          starve_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] ram     [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};
    logic [7:0] ref_mem [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00};

    sort_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve_err(starve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: accepted reads push the expected word; the following cycle pops and compares it.
    always @(negedge clk) begin
        exp_t e;
        logic e0, e1;
        logic [7:0] ed;
        if (rst) begin
            exp_q.delete();
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_rvalid0", rvalid0, 0);
            chk("rst_rvalid1", rvalid1, 0);
        end else begin
            e0 = 1'b0; e1 = 1'b0; ed = 8'h00;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                e0 = (e.port == 1'b0);
                e1 = (e.port == 1'b1);
                ed = e.data;
            end
            chk("sb_rvalid0", rvalid0, e0);
            chk("sb_rvalid1", rvalid1, e1);
            if (e0 || e1) chk("sb_rdata", rdata, ed);
            chk("gnt_onehot", gnt0 & gnt1, 0);
            chk("gnt0_implies_req0", gnt0 & ~req0, 0);
            chk("gnt1_implies_req1", gnt1 & ~req1, 0);
            if (gnt0 && req0) begin
                chk("mem_en0", mem_en, 1);
                chk("mem_we0", mem_we, we0);
                chk("mem_addr0", mem_addr, addr0);
                if (we0) begin
                    chk("mem_wdata0", mem_wdata, wdata0);
                    ref_mem[addr0] = wdata0;
                end else begin
                    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[addr0]});
                end
            end else if (gnt1 && req1) begin
                chk("mem_en1", mem_en, 1);
                chk("mem_we1", mem_we, we1);
                chk("mem_addr1", mem_addr, addr1);
                if (we1) begin
                    chk("mem_wdata1", mem_wdata, wdata1);
                    ref_mem[addr1] = wdata1;
                end else begin
                    exp_q.push_back('{cyc + 1, 1'b1, ref_mem[addr1]});
                end
            end else begin
                chk("idle_mem_en", mem_en, 0);
                chk("idle_mem_we", mem_we, 0);
                chk("idle_mem_addr", mem_addr, 0);
                chk("idle_mem_wdata", mem_wdata, 0);
            end
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic l0, input logic [2:0] a0,
                         input logic [7:0] d0, input logic r1, input logic w1, input logic l1,
                         input logic [2:0] a1, input logic [7:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0, 8'h00);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_starve", starve_err, 0);
        next();
        rst = 1'b0;

        // Single host read of addr 5
        drive(1, 0, 0, 3'd5, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_mem_addr", mem_addr, 5);
        next();
        idle();
        @(negedge clk);
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rdata", rdata, 8'h3C);
        next();

        // Reset leaves ptr at 0, so contention alternates starting at port 0
        rst = 1'b1;
        @(negedge clk);
        next();
        rst = 1'b0;
        drive(1, 0, 0, 3'd1, 8'h00, 1, 0, 0, 3'd5, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_gnt0", gnt0, (i % 2) == 0);
            chk("t2_gnt1", gnt1, (i % 2) == 1);
            next();
        end
        idle();

        // Port 1 writes 0xA5 to addr 2, then port 0 reads it back
        drive(0, 0, 0, 3'd0, 8'h00, 1, 1, 0, 3'd2, 8'hA5);
        @(negedge clk);
        chk("t3_gnt1", gnt1, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_mem_wdata", mem_wdata, 8'hA5);
        next();
        drive(1, 0, 0, 3'd2, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        chk("t3_gnt0", gnt0, 1);
        next();
        idle();
        @(negedge clk);
        chk("t3_rvalid0", rvalid0, 1);
        chk("t3_rvalid1", rvalid1, 0);
        chk("t3_rdata", rdata, 8'hA5);
        chk("t3_starve", starve_err, 0);
        next();

        // Port 1 takes the lock, then holds it for 10 cycles while port 0 waits
        drive(0, 0, 0, 3'd0, 8'h00, 1, 0, 1, 3'd2, 8'h00);
        @(negedge clk);
        chk("t4_lock_gnt1", gnt1, 1);
        next();
        drive(1, 0, 0, 3'd5, 8'h00, 1, 0, 1, 3'd2, 8'h00);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            chk("t4_locked_gnt0", gnt0, 0);
            chk("t4_locked_gnt1", gnt1, 1);
            // Flag registers at the edge completing the 4th wait cycle
            chk("t4_starve", starve_err, j >= 5);
            next();
        end
        drive(1, 0, 0, 3'd5, 8'h00, 1, 0, 0, 3'd2, 8'h00);
        @(negedge clk);
        chk("t4_release_gnt0", gnt0, 1);
        chk("t4_release_gnt1", gnt1, 0);
        chk("t4_starve_hold", starve_err, 1);
        next();
        idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_starve_sticky", starve_err, 1);
            next();
        end

        // Locked host read, then reset in the following cycle
        rst = 1'b1;
        @(negedge clk);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_starve_cleared", starve_err, 0);
        drive(1, 0, 1, 3'd5, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        chk("t5_gnt0", gnt0, 1);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rvalid_discard", rvalid0, 0);
        chk("t5_rst_gnt0", gnt0, 0);
        next();
        rst = 1'b0;
        drive(0, 0, 1, 3'd0, 8'h00, 1, 0, 0, 3'd3, 8'h00);
        @(negedge clk);
        chk("t5_lock_released", gnt1, 1);
        chk("t5_no_rvalid0", rvalid0, 0);
        next();
        idle();
        @(negedge clk);
        next();
        @(negedge clk);
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
